// File: rtl/fifo_pkg.sv
// Shared definitions for both sides of the asynchronous FIFO: default sizes
// and the Gray/binary pointer conversions.
package fifo_pkg;

    localparam int DEF_D_SIZE  = 8;
    localparam int DEF_F_DEPTH = 8;
    localparam int DEF_P_SIZE  = 4;

    // Operates on a 32-bit container; callers size-cast to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/double_flop_sync.sv
// Two-stage clock-domain-crossing synchronizer for a Gray-coded bus,
// shared by the read and write sides of the FIFO.
module double_flop_sync #(
    parameter int BUS_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] d,
    output logic [BUS_WIDTH-1:0] q
);

    logic [BUS_WIDTH-1:0] stage1;

    // Nothing may sit between the two stages, or metastability gets a path out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/fifo_rd_port.sv
// Read side of an asynchronous FIFO with a registered output stage.
// Define FIFO_RD_LEVEL_EN to add the registered r_level occupancy output.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int D_SIZE  = DEF_D_SIZE,
    parameter int F_DEPTH = DEF_F_DEPTH,
    parameter int P_SIZE  = DEF_P_SIZE
) (
    input  logic              r_clk,
    input  logic              r_rstn,
    input  logic [P_SIZE-1:0] w_gptr,
    input  logic [D_SIZE-1:0] mem_rdata,
    output logic [P_SIZE-2:0] r_addr,
    output logic [P_SIZE-1:0] r_gptr,
    output logic              r_empty,
    output logic [D_SIZE-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [P_SIZE-1:0] r_level
`endif
);

    // The wrap bit scheme only works when the depth is exactly half the pointer range.
    if (F_DEPTH != (1 << (P_SIZE - 1))) begin : g_depth_check
        $error("fifo_rd_port: F_DEPTH must equal 2**(P_SIZE-1)");
    end

    logic [P_SIZE-1:0] wq2_gptr;
    logic [P_SIZE-1:0] r_bptr;
    logic [P_SIZE-1:0] r_bptr_next;
    logic [P_SIZE-1:0] r_gptr_next;
    logic              pop;

    double_flop_sync #(
        .BUS_WIDTH (P_SIZE)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rstn),
        .d     (w_gptr),
        .q     (wq2_gptr)
    );

    // A word leaves memory whenever there is one and the output stage is free or being drained.
    assign pop         = !r_empty && (!out_valid || out_ready);
    assign r_bptr_next = r_bptr + {{(P_SIZE - 1){1'b0}}, pop};
    assign r_gptr_next = P_SIZE'(bin2gray(32'(r_bptr_next)));
    assign r_addr      = r_bptr[P_SIZE-2:0];

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            r_bptr  <= '0;
            r_gptr  <= '0;
            r_empty <= 1'b1;
        end else begin
            r_bptr  <= r_bptr_next;
            r_gptr  <= r_gptr_next;
            r_empty <= (r_gptr_next == wq2_gptr);
        end
    end

    // Output stage: loading on pop and clearing on accept-without-refill gives one word per cycle.
    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [P_SIZE-1:0] wq2_bptr;

    assign wq2_bptr = P_SIZE'(gray2bin(32'(wq2_gptr)));

    // Unsigned modulo subtraction keeps the level right across pointer wrap.
    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            r_level <= '0;
        end else begin
            r_level <= wq2_bptr - r_bptr;
        end
    end
`endif

endmodule
